// File: rtl/jk_seq_detect.sv
// jk_seq_detect: serial pattern detector observing the Q output of a JK flip-flop.
// Ports: CLK/RST (async active-high) clock and reset; EN sample enable; CLR synchronous clear;
//   Q serial input; DET one-cycle match pulse; HIT_CNT saturating match count; SAT counter full;
//   Q_RISE/Q_FALL sampled-edge pulses; STATE debug FSM state (0 IDLE, 1 FILL, 2 ARMED).
// Latency 1 cycle from the completing sample to DET; no backpressure (every enabled edge is consumed).
// Optional feature macro SEQ_OVERLAP_EN: when defined, matches may overlap; default is non-overlapping.
module jk_seq_detect #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CLR,
   input  logic             Q,
   output logic             DET,
   output logic [CNT_W-1:0] HIT_CNT,
   output logic             SAT,
   output logic             Q_RISE,
   output logic             Q_FALL,
   output logic [1:0]       STATE
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_ARMED = 2'd2
   } state_e;

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

   state_e             state_q;
   logic [PAT_LEN-1:0] win_q;
   logic [FILL_W-1:0]  fill_q;
   logic [CNT_W-1:0]   hit_cnt_q;
   logic               det_q;
   logic               rise_q;
   logic               fall_q;
   logic               prev_q;
   logic               prev_vld_q;

   // Next values, applied only on sampled (EN=1, CLR=0) edges.
   logic [PAT_LEN-1:0] win_d;
   logic [FILL_W-1:0]  fill_d;
   state_e             state_d;
   logic               match_d;

   always_comb begin
      win_d   = {win_q[PAT_LEN-2:0], Q};
      // The window only holds a full pattern once PAT_LEN-1 older bits are valid.
      match_d = (fill_q >= FILL_LAST) && (win_d == PATTERN);
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
`ifdef SEQ_OVERLAP_EN
      // Overlapping: the matched bits stay in the window and may start the next match.
`else
      // Non-overlapping: forget the matched bits; the window keeps shifting but is
      // ignored until PAT_LEN fresh samples have been taken.
      if (match_d) begin
         fill_d  = '0;
         state_d = ST_IDLE;
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         win_q      <= '0;
         fill_q     <= '0;
         hit_cnt_q  <= '0;
         det_q      <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         prev_q     <= 1'b0;
         prev_vld_q <= 1'b0;
      end else if (CLR) begin
         // Clear wins over a simultaneous sample, even a completing one.
         state_q    <= ST_IDLE;
         win_q      <= '0;
         fill_q     <= '0;
         hit_cnt_q  <= '0;
         det_q      <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         prev_q     <= 1'b0;
         prev_vld_q <= 1'b0;
      end else begin
         det_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (EN) begin
            win_q      <= win_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            prev_q     <= Q;
            prev_vld_q <= 1'b1;
            rise_q     <= prev_vld_q & ~prev_q & Q;
            fall_q     <= prev_vld_q & prev_q & ~Q;
            if (match_d) begin
               det_q <= 1'b1;
               if (!(&hit_cnt_q)) begin
                  hit_cnt_q <= hit_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   assign DET     = det_q;
   assign HIT_CNT = hit_cnt_q;
   assign SAT     = &hit_cnt_q;
   assign Q_RISE  = rise_q;
   assign Q_FALL  = fall_q;
   assign STATE   = state_q;

endmodule

// File: tb/tb_jk_seq_detect.sv
// tb_jk_seq_detect: scoreboard bench for jk_seq_detect with a queue-based reference model.
// Stimulus pushes expected post-edge outputs tagged with the clock edge index; a monitor pops and compares.
// The model keeps the sampled bits since the last restart and matches them arithmetically against the pattern.
module tb_jk_seq_detect;

   localparam int                 PAT_LEN = 4;
   localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;
   localparam int                 CNT_W   = 2;
   localparam int                 HIT_MAX = (1 << CNT_W) - 1;

   logic             CLK;
   logic             RST;
   logic             EN;
   logic             CLR;
   logic             Q;
   logic             DET;
   logic [CNT_W-1:0] HIT_CNT;
   logic             SAT;
   logic             Q_RISE;
   logic             Q_FALL;
   logic [1:0]       STATE;

   jk_seq_detect #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN),
      .CNT_W   (CNT_W)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .CLR     (CLR),
      .Q       (Q),
      .DET     (DET),
      .HIT_CNT (HIT_CNT),
      .SAT     (SAT),
      .Q_RISE  (Q_RISE),
      .Q_FALL  (Q_FALL),
      .STATE   (STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int edge_cnt = 0;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int edge_idx;
      int det;
      int hit;
      int sat;
      int rise;
      int fall;
      int st;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   bit m_hist[$];
   bit m_prev;
   bit m_prev_vld;
   int m_hit;

   function automatic void model_clear(input bit keep_hit);
      m_hist.delete();
      m_prev     = 1'b0;
      m_prev_vld = 1'b0;
      if (!keep_hit) m_hit = 0;
   endfunction

   function automatic exp_t zero_exp(input int idx);
      exp_t e;
      e.edge_idx = idx;
      e.det = 0; e.hit = 0; e.sat = 0; e.rise = 0; e.fall = 0; e.st = 0;
      return e;
   endfunction

   function automatic exp_t model_edge(input bit en, input bit clr, input bit q, input int idx);
      exp_t e;
      int   v;
      e = zero_exp(idx);
      if (clr) begin
         model_clear(1'b0);
      end else if (en) begin
         e.rise = (m_prev_vld && !m_prev && q) ? 1 : 0;
         e.fall = (m_prev_vld && m_prev && !q) ? 1 : 0;
         m_prev     = q;
         m_prev_vld = 1'b1;
         m_hist.push_back(q);
         if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
         v = 0;
         foreach (m_hist[i]) v = v * 2 + int'(m_hist[i]);
         if (m_hist.size() == PAT_LEN && v == int'(PATTERN)) begin
            e.det = 1;
            if (m_hit < HIT_MAX) m_hit++;
`ifndef SEQ_OVERLAP_EN
            m_hist.delete();
`endif
         end
      end
      e.hit = m_hit;
      e.sat = (m_hit == HIT_MAX) ? 1 : 0;
      if (m_hist.size() == 0)            e.st = 0;
      else if (m_hist.size() < PAT_LEN)  e.st = 1;
      else                               e.st = 2;
      return e;
   endfunction

   function automatic void chk(input string name, input int idx, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL edge %0d %s: got %0d expected %0d", idx, name, got, exp);
      end
   endfunction

   // Monitor: compares every expectation whose edge has occurred; also wakes on reset
   // assertion so asynchronous clearing is checked before the next clock edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK or posedge RST);
         #1;
         while (sb.size() > 0 && sb[0].edge_idx <= edge_cnt) begin
            e = sb.pop_front();
            chk("DET",     e.edge_idx, int'(DET),     e.det);
            chk("HIT_CNT", e.edge_idx, int'(HIT_CNT), e.hit);
            chk("SAT",     e.edge_idx, int'(SAT),     e.sat);
            chk("Q_RISE",  e.edge_idx, int'(Q_RISE),  e.rise);
            chk("Q_FALL",  e.edge_idx, int'(Q_FALL),  e.fall);
            chk("STATE",   e.edge_idx, int'(STATE),   e.st);
         end
      end
   end

   // One cycle of stimulus, applied for exactly one rising edge.
   task automatic step(input bit en, input bit clr, input bit q);
      @(negedge CLK);
      #3;
      EN  = en;
      CLR = clr;
      Q   = q;
      sb.push_back(model_edge(en, clr, q, edge_cnt + 1));
      @(posedge CLK);
      #1;
      EN  = 1'b0;
      CLR = 1'b0;
   endtask

   task automatic seq(input bit [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b0, bits[i]);
   endtask

   // Asynchronous reset asserted between edges.
   task automatic do_reset();
      @(negedge CLK);
      #3;
      EN  = 1'b0;
      CLR = 1'b0;
      sb.push_back(zero_exp(edge_cnt));
      model_clear(1'b0);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      #3;
      RST = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      EN  = 1'b0;
      CLR = 1'b0;
      Q   = 1'b0;
      RST = 1'b1;
      model_clear(1'b0);
      sb.push_back(zero_exp(0));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #3;
      RST = 1'b0;

      // Basic match plus edge pulses
      seq(16'b1011, 4);
      // Continuous 1011011: overlap-dependent second match
      do_reset();
      seq(16'b1011011, 7);
      // Gap of EN=0 edges does not break the pattern
      do_reset();
      seq(16'b10, 2);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      seq(16'b11, 2);
      // Six matches saturate the 2-bit counter
      do_reset();
      repeat (6) seq(16'b1011, 4);
      // Reset mid-window discards partial history
      do_reset();
      seq(16'b101, 3);
      do_reset();
      seq(16'b11, 2);
      // CLR beats a completing sample
      do_reset();
      seq(16'b101, 3);
      step(1'b1, 1'b1, 1'b1);
      seq(16'b1011, 4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3, 1'($urandom_range(0, 1)));
         end
      end

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_seq_detect.md
Name: jk_seq_detect

Overview:
- Downstream consumer of the JK flip-flop stage; samples its Q output on each rising CLK while EN=1.
- Detects a programmable serial bit pattern, emits a one-cycle DET pulse per match and keeps a saturating hit count.
- Also reports registered rising/falling edges of the sampled Q stream.
- Used as the self-checking observer behind the JK stage in lab benches and as a building block for later sequence labs.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, target pattern; MSB is the oldest bit, LSB the newest.
- CNT_W, 8, width of the hit counter.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  sample enable; Q is sampled only on edges where EN=1.
- CLR  input  1  synchronous clear of the window, state, counter and edge history.
- Q  input  1  serial bit from the upstream JK flip-flop.
- DET  output  1  one-cycle registered match pulse.
- HIT_CNT  output  CNT_W  number of matches since reset/CLR, saturating.
- SAT  output  1  high while HIT_CNT is all ones.
- Q_RISE  output  1  one-cycle pulse: sampled Q went 0->1.
- Q_FALL  output  1  one-cycle pulse: sampled Q went 1->0.
- STATE  output  2  current FSM state, for debug.

Behaviour:
- Reset (RST=1, asynchronous): DET=0, HIT_CNT=0, SAT=0, Q_RISE=0, Q_FALL=0, STATE=IDLE, window=0, fill=0, prev-sample-valid=0. A reset asserted mid-window discards all partial history.
- FSM encoding: IDLE=2'd0 (no samples yet), FILL=2'd1 (1..PAT_LEN-1 valid bits), ARMED=2'd2 (full window).
- IDLE -> FILL on the first sampled edge.
- FILL -> ARMED when the fill count reaches PAT_LEN-1 and another sample arrives.
- ARMED stays ARMED, except on a match without SEQ_OVERLAP_EN (see Optional Feature).
- Window update on a sampled edge: window <= {window[PAT_LEN-2:0], Q}; fill saturates at PAT_LEN.
- Match condition: fill >= PAT_LEN-1 before the edge and {window[PAT_LEN-2:0], Q} == PATTERN.
- DET is set at the same edge, so it is high for exactly the following cycle (latency 1 cycle from the completing sample). DET=0 on every edge with no match, including EN=0 edges.
- HIT_CNT increments by 1 on each match while not all ones; it holds at 2^CNT_W-1. SAT is combinational (HIT_CNT == all ones). DET still pulses when saturated.
- Edge pulses: compare the sampled Q with the previously sampled Q. No pulse on the very first sample after reset/CLR. Pulses last 1 cycle and are 0 on non-sampled edges.
- EN=0 edges: window, fill, STATE and HIT_CNT hold. Gaps do not break a pattern.
- CLR=1 at an edge: window=0, fill=0, HIT_CNT=0, DET=0, Q_RISE=0, Q_FALL=0, prev-sample-valid=0, STATE=IDLE.
- CLR has priority over EN: a sample on the same edge is discarded, even if it would complete a match.

Optional Feature:
- Macro: SEQ_OVERLAP_EN.
- Defined: overlapping detection. After a match the window and fill are kept and STATE stays ARMED, so a pattern suffix may start the next match.
- Undefined (default): non-overlapping detection. On a match, fill is cleared to 0 and STATE goes to IDLE. The matching edge still updates the edge history; the next match needs PAT_LEN fresh samples.

Test Plan:
- RST pulse, then EN=1, Q=1,0,1,1 on four edges -> DET=1 for one cycle after the 4th edge only; HIT_CNT=1.
- Same run, Q_RISE/Q_FALL check -> Q_FALL after edge 2, Q_RISE after edge 3, no edge pulse after edge 1 or edge 4.
- Q=1,0,1,1,0,1,1 continuous -> without SEQ_OVERLAP_EN: one DET, HIT_CNT=1. With SEQ_OVERLAP_EN: DETs after edges 4 and 7, HIT_CNT=2.
- Q=1,0, then 3 edges with EN=0 and Q=0, then EN=1 with Q=1,1 -> DET after the last edge; STATE stays FILL through the gap.
- CNT_W=2, six non-overlapping 1011 matches -> HIT_CNT reaches 3 after match 3 and holds at 3; SAT=1 from then on; DET pulses on all six matches.
- After 1,0,1 sampled, assert RST asynchronously between edges -> all outputs 0 immediately, STATE=0. Then 1,1 -> no DET.
- After 1,0,1 sampled, CLR=1 and EN=1 with Q=1 on the same edge -> DET=0, HIT_CNT=0, STATE=IDLE.
